// File: rtl/access_pkg.sv
// Shared definitions for the access requester: FSM state encoding,
// parameter defaults and grant-line decode helpers.
package access_pkg;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        PRESENT,
        CONF1,
        GAP,
        CONF2,
        WAIT,
        GRANTED,
        DENIED
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 8;
    localparam int unsigned CONFIRM_GAP_DEFAULT    = 1;
    localparam int unsigned TIMER_W                = 4;

    // Expected line high and the other line low.
    function automatic logic grant_ok(input logic sel, input logic p, input logic q);
        return sel ? (q && !p) : (p && !q);
    endfunction

    // Non-expected line high, with or without the expected one.
    function automatic logic grant_bad(input logic sel, input logic p, input logic q);
        return sel ? p : q;
    endfunction

    function automatic logic expected_line(input logic sel, input logic p, input logic q);
        return sel ? q : p;
    endfunction

endpackage

// File: rtl/grant_timer.sv
// Saturating grant-wait counter with a registered expiry flag.
module grant_timer
    import access_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_inc;
    logic               expired_q;

    always_comb begin
        count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
    end

    // expired_q is computed one count ahead so that during the Nth enabled
    // cycle it already reads (N >= LIMIT).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (clear) begin
            count_q   <= '0;
            expired_q <= (LIMIT <= 1);
        end else if (enable) begin
            count_q   <= count_inc;
            expired_q <= (32'(count_inc) + 32'd1 >= LIMIT);
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/access_requester.sv
// Access requester: presents {sel,code}, emits a double confirm strobe and
// waits for the selected grant line, with timeout, abort and hold handling.
module access_requester
    import access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned CONFIRM_GAP    = CONFIRM_GAP_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] code,
    input  logic       sel,
    input  logic       hold,
    input  logic       abort,
    input  logic       regP,
    input  logic       regQ,
    output logic       request,
    output logic       confirm,
    output logic [7:0] user,
    output logic       busy,
    output logic       granted,
    output logic       denied
);

    state_t      state_q, state_d;
    logic [1:0]  gap_q, gap_d;
    logic [7:0]  user_q, user_d;
    logic        request_q, confirm_q, busy_q, granted_q, denied_q;
    logic        timer_clear, timer_enable, timer_expired;

    assign timer_clear  = (state_q == CONF2);
    assign timer_enable = (state_q == WAIT);

    grant_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_grant_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        user_d  = user_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    user_d  = {sel, code};
                end
            end
            REQ:     state_d = PRESENT;
            PRESENT: state_d = CONF1;
            CONF1: begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: begin
                if (gap_q == 2'(CONFIRM_GAP - 1)) state_d = CONF2;
                else                              gap_d   = gap_q + 2'd1;
            end
            CONF2:   state_d = WAIT;
            WAIT: begin
                if (grant_ok(user_q[7], regP, regQ))       state_d = GRANTED;
                else if (grant_bad(user_q[7], regP, regQ)) state_d = DENIED;
                else if (timer_expired)                    state_d = DENIED;
            end
            GRANTED: begin
                if (!hold || !expected_line(user_q[7], regP, regQ)) state_d = IDLE;
            end
            DENIED:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides every other transition, including a same-cycle grant.
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            user_q    <= '0;
            request_q <= 1'b0;
            confirm_q <= 1'b0;
            busy_q    <= 1'b0;
            granted_q <= 1'b0;
            denied_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            user_q    <= user_d;
            request_q <= state_d inside {REQ, PRESENT, CONF1, GAP, CONF2, WAIT, GRANTED};
            confirm_q <= state_d inside {CONF1, CONF2};
            busy_q    <= (state_d != IDLE);
            granted_q <= (state_d == GRANTED);
            denied_q  <= (state_d == DENIED);
        end
    end

    assign request = request_q;
    assign confirm = confirm_q;
    assign user    = user_q;
    assign busy    = busy_q;
    assign granted = granted_q;
    assign denied  = denied_q;

endmodule

// File: tb/tb_access_requester.sv
// Self-checking bench: each attempt's full output trace is derived from the
// sequence timing rules and compared cycle by cycle.
module tb_access_requester;

    localparam int unsigned T = 8;
    localparam int unsigned G = 1;

    logic       clock = 1'b0;
    logic       reset, start, sel, hold, abort, regP, regQ;
    logic [6:0] code;
    logic       request, confirm, busy, granted, denied;
    logic [7:0] user;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] prev_user   = 8'h00;

    always #5 clock = ~clock;

    access_requester #(
        .TIMEOUT_CYCLES(T),
        .CONFIRM_GAP   (G)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .code   (code),
        .sel    (sel),
        .hold   (hold),
        .abort  (abort),
        .regP   (regP),
        .regQ   (regQ),
        .request(request),
        .confirm(confirm),
        .user   (user),
        .busy   (busy),
        .granted(granted),
        .denied (denied)
    );

    // kind: 0 no line, 1 expected line, 2 wrong line, 3 both lines;
    // jg: WAIT cycle (1-based) in which the lines appear; H: GRANTED length;
    // a / s2 / rst_c: cycle of abort / second start / mid-cycle reset (0 = none).
    task automatic run_attempt(input string name, input logic a_sel, input logic [6:0] a_code,
                               input int kind, input int jg, input int H, input bit by_line,
                               input int a, input int s2, input int rst_c);
        int w, E, g0, eff_e, line_end;
        bit grant_out, deny_out, in_win;
        logic req_e, conf_e, busy_e, gr_e, den_e;
        logic [7:0] u_e;
        logic [12:0] exp_v, act_v;
        w = 5 + int'(G);
        g0 = 0;
        grant_out = 0;
        if (kind != 0 && jg <= int'(T)) begin
            if (kind == 1) begin
                grant_out = 1;
                g0 = w + jg;
                E = g0 + H - 1;
            end else begin
                E = w + jg;
            end
        end else begin
            E = w + int'(T);
        end
        deny_out = !grant_out;
        eff_e = E;
        if (a >= 1 && a < eff_e) eff_e = a;
        if (rst_c >= 1 && rst_c < eff_e) eff_e = rst_c;
        line_end = by_line ? g0 + H - 2 : g0 + H - 1;
        for (int c = 0; c <= eff_e + 2; c++) begin
            if (c > 0) begin
                @(posedge clock);
                #1;
            end
            busy_e = (c >= 1 && c <= eff_e);
            req_e  = busy_e && !(deny_out && c == E);
            conf_e = busy_e && (c == 3 || c == 4 + int'(G));
            gr_e   = grant_out && c >= g0 && c <= eff_e;
            den_e  = deny_out && c == E && c <= eff_e;
            if (c == 0) u_e = prev_user;
            else if (rst_c >= 1 && c > rst_c) u_e = 8'h00;
            else u_e = {a_sel, a_code};
            exp_v = {req_e, conf_e, u_e, busy_e, gr_e, den_e};
            act_v = {request, confirm, user, busy, granted, denied};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got req=%b conf=%b user=%h busy=%b gnt=%b den=%b, expected req=%b conf=%b user=%h busy=%b gnt=%b den=%b",
                         name, c, request, confirm, user, busy, granted, denied,
                         req_e, conf_e, u_e, busy_e, gr_e, den_e);
            end

            start = (c == 0) || (s2 >= 1 && c == s2 && c <= eff_e);
            abort = (a >= 1 && c == a && c <= eff_e);
            if (c == 0) begin
                sel  = a_sel;
                code = a_code;
            end else begin
                sel  = 1'($urandom);
                code = 7'($urandom);
            end
            hold = grant_out ? (by_line ? 1'b1 : (c < g0 + H - 1)) : 1'($urandom);
            in_win = (jg <= int'(T)) && c <= eff_e;
            regP = 1'b0;
            regQ = 1'b0;
            if (c < w && c <= eff_e) begin
                regP = 1'($urandom);
                regQ = 1'($urandom);
            end else if (in_win && kind == 1 && c >= w + jg - 1 && c <= line_end) begin
                regP = !a_sel;
                regQ = a_sel;
            end else if (in_win && kind == 2 && c == w + jg - 1) begin
                regP = a_sel;
                regQ = !a_sel;
            end else if (in_win && kind == 3 && c == w + jg - 1) begin
                regP = 1'b1;
                regQ = 1'b1;
            end

            if (rst_c >= 1 && c == rst_c) begin
                #2 reset = 1'b1;
                #1;
                vectors++;
                if ({request, confirm, user, busy, granted, denied} !== 13'h0) begin
                    miscompares++;
                    $display("FAIL %s async reset: got req=%b conf=%b user=%h busy=%b gnt=%b den=%b, expected all 0",
                             name, request, confirm, user, busy, granted, denied);
                end
                #2 reset = 1'b0;
            end
        end
        prev_user = (rst_c >= 1) ? 8'h00 : {a_sel, a_code};
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
        regP  = 1'b0;
        regQ  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        hold  = 1'b0;
        regP  = 1'b0;
        regQ  = 1'b0;
        sel   = 1'b1;
        code  = 7'h55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            vectors++;
            if ({request, confirm, user, busy, granted, denied} !== 13'h0) begin
                miscompares++;
                $display("FAIL reset_held: got req=%b conf=%b user=%h busy=%b gnt=%b den=%b, expected all 0",
                         request, confirm, user, busy, granted, denied);
            end
        end
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if ({request, confirm, user, busy, granted, denied} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_release: got req=%b conf=%b user=%h busy=%b gnt=%b den=%b, expected all 0",
                     request, confirm, user, busy, granted, denied);
        end
        prev_user = 8'h00;
    endtask

    task automatic test_basic_grant();
        run_attempt("basic_grant_p", 1'b0, 7'h03, 1, 2, 5, 1'b0, 0, 0, 0);
    endtask

    task automatic test_sel_q();
        run_attempt("grant_q", 1'b1, 7'h2a, 1, 1, 3, 1'b0, 0, 0, 0);
        run_attempt("deny_wrong_line", 1'b1, 7'h11, 2, 3, 1, 1'b0, 0, 0, 0);
        run_attempt("deny_both_lines", 1'b0, 7'h7f, 3, 1, 1, 1'b0, 0, 0, 0);
        run_attempt("grant_line_drop", 1'b0, 7'h40, 1, 4, 3, 1'b1, 0, 0, 0);
    endtask

    task automatic test_timeout();
        run_attempt("timeout", 1'b0, 7'h05, 0, 1, 1, 1'b0, 0, 0, 0);
        run_attempt("grant_last_wait", 1'b1, 7'h06, 1, int'(T), 2, 1'b0, 0, 0, 0);
        run_attempt("grant_too_late", 1'b0, 7'h07, 1, int'(T) + 1, 2, 1'b0, 0, 0, 0);
    endtask

    task automatic test_abort();
        run_attempt("abort_gap", 1'b1, 7'h33, 1, 2, 2, 1'b0, 4, 2, 0);
        run_attempt("abort_beats_grant", 1'b0, 7'h21, 1, 2, 3, 1'b0, 5 + int'(G) + 1, 0, 0);
        run_attempt("abort_granted", 1'b1, 7'h0c, 1, 1, 6, 1'b0, 5 + int'(G) + 3, 3, 0);
    endtask

    task automatic test_reset_granted();
        run_attempt("reset_in_granted", 1'b0, 7'h19, 1, 1, 5, 1'b0, 0, 0, 5 + int'(G) + 2);
        run_attempt("start_after_reset", 1'b1, 7'h44, 1, 2, 2, 1'b0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int kind, jg, h, a, s2;
        bit by_line;
        for (int n = 0; n < 40; n++) begin
            kind    = int'($urandom_range(0, 3));
            jg      = int'($urandom_range(1, T + 2));
            h       = int'($urandom_range(1, 6));
            by_line = 1'($urandom);
            a       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : 0;
            s2      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0;
            run_attempt("random", 1'($urandom), 7'($urandom), kind, jg, h, by_line, a, s2, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_sel_q();
        test_timeout();
        test_abort();
        test_reset_granted();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/access_requester.md
ACCESS_REQUESTER -- requirements
Module: access_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8, giving the grant-wait limit in clocks (range 1..15).
REQ-002 SHALL have parameter CONFIRM_GAP, default 1, giving the confirm-low clocks between the two confirm pulses (range 1..3).
REQ-003 SHALL use one clock, clock; reset is asynchronous and active-high, port reset.
REQ-004 clock  input  1  system clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins an access attempt; sampled only in IDLE.
REQ-007 code  input  7  access code; captured on the accepted start.
REQ-008 sel  input  1  target select, 0 = P line, 1 = Q line; captured with code.
REQ-009 hold  input  1  keep access open while high after grant.
REQ-010 abort  input  1  cancel the attempt from any non-IDLE state.
REQ-011 regP  input  1  grant line P from the access controller.
REQ-012 regQ  input  1  grant line Q from the access controller.
REQ-013 request  output  1  session request to the controller, registered.
REQ-014 confirm  output  1  confirm strobe to the controller, registered.
REQ-015 user  output  8  {sel, code} presented to the controller, registered.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 granted  output  1  high while in GRANTED.
REQ-018 denied  output  1  one-cycle pulse when an attempt fails or times out.

Function
REQ-019 SHALL use states IDLE, REQ, PRESENT, CONF1, GAP, CONF2, WAIT, GRANTED, DENIED.
REQ-020 IDLE with start=1 SHALL capture {sel,code} into user and go to REQ; request rises in the next cycle.
REQ-021 REQ SHALL hold request=1, confirm=0 for one cycle, then go to PRESENT.
REQ-022 PRESENT SHALL hold request=1, confirm=0, user stable for one cycle, then go to CONF1.
REQ-023 CONF1 SHALL drive confirm=1 for exactly one cycle, then go to GAP.
REQ-024 GAP SHALL drive confirm=0 for CONFIRM_GAP cycles, then go to CONF2.
REQ-025 CONF2 SHALL drive confirm=1 for exactly one cycle, then go to WAIT with the timeout counter cleared.
REQ-026 WAIT: expected line (regP if sel=0, regQ if sel=1) high and other line low SHALL go to GRANTED.
REQ-027 WAIT: the non-expected line high, or both lines high, SHALL go to DENIED.
REQ-028 WAIT: no grant after TIMEOUT_CYCLES counted cycles SHALL go to DENIED; the counter saturates and never wraps.
REQ-029 GRANTED SHALL keep request=1 while hold=1; with hold=0, or the expected line dropping, SHALL go to IDLE with request=0 next cycle.
REQ-030 DENIED SHALL drive request=0 and denied=1 for one cycle, then go to IDLE.
REQ-031 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with request=0 and confirm=0; no denied pulse.
REQ-032 abort and a grant in the same WAIT cycle: abort SHALL win.
REQ-033 start while busy SHALL be ignored; user SHALL NOT change outside IDLE.
REQ-034 confirm SHALL never be high while request is low.

Reset
REQ-035 reset=1 SHALL force IDLE immediately: request=0, confirm=0, user=8'h00, busy=0, granted=0, denied=0, counter=0.
REQ-036 reset mid-attempt SHALL drop request asynchronously; the first start after reset deassertion SHALL be honoured.

Structure
REQ-037 State encodings and the TIMEOUT_CYCLES and CONFIRM_GAP defaults SHALL live in a shared package, access_pkg.
REQ-038 The timeout counter SHALL be a sub-module, grant_timer, with inputs clear and enable and a registered expired output.

Verification
REQ-039 Reset held, then released -> all outputs 0 and state IDLE.
REQ-040 start, code=7'h03, sel=0, regP=1 two cycles after CONF2, hold=1 for 5 cycles -> request high cycles 1..N, confirm pulses in cycles 3 and 5, granted high for 5 cycles, then request=0.
REQ-041 start, sel=1, regQ=1 in WAIT -> granted; regP=1 instead -> one denied pulse, request=0.
REQ-042 start, no grant -> denied pulse exactly TIMEOUT_CYCLES=8 cycles after entering WAIT.
REQ-043 abort asserted in GAP -> request and confirm 0 next cycle, no denied; a second start pulse during the attempt -> user unchanged.
REQ-044 reset asserted in GRANTED -> request 0 without waiting for a clock edge; next start -> normal sequence.
